// File: rtl/io_reset_conditioner_pkg.sv
// Shared definitions for io_reset_conditioner: one-hot reset-FSM encoding and counter sizing.
package io_cond_pkg;

  localparam int ST_POR  = 0;
  localparam int ST_HOLD = 1;
  localparam int ST_RUN  = 2;

  typedef enum logic [2:0] {
    S_POR  = 3'b001,
    S_HOLD = 3'b010,
    S_RUN  = 3'b100
  } state_e;

  // Width of a counter that must reach n-1 without wrapping.
  function automatic int ctr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_reset_conditioner_sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing WIDTH asynchronous bits into the clk domain.
module sync_chain #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage = {STAGES{RESET_VAL}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= {STAGES{RESET_VAL}};
    end else begin
      r_stage <= {r_stage[STAGES-2:0], d};
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/io_reset_conditioner.sv
// io_reset_conditioner: input synchronisers, button debounce and POR/button reset sequencer.
// Optional macro IO_COND_EDGE_EN builds the rise/fall detectors; otherwise they are tied low.
module io_reset_conditioner
  import io_cond_pkg::*;
#(
  parameter int                NUM_IN          = 2,
  parameter int                SYNC_STAGES     = 2,
  parameter logic [NUM_IN-1:0] SYNC_RESET_VAL  = {NUM_IN{1'b1}},
  parameter int                BTN_ACTIVE_LOW  = 1,
  parameter int                DEBOUNCE_CYCLES = 16,
  parameter int                POR_CYCLES      = 4,
  parameter int                HOLD_CYCLES     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_ext,
  input  logic [NUM_IN-1:0] async_in,
  output logic [NUM_IN-1:0] sync_out,
  output logic [NUM_IN-1:0] rise,
  output logic [NUM_IN-1:0] fall,
  output logic              btn_pressed,
  output logic              por_done,
  output logic              sys_resetn
);

  localparam logic BTN_REL = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam int   DB_W    = ctr_width(DEBOUNCE_CYCLES);
  localparam int   FSM_W   = ctr_width((POR_CYCLES > HOLD_CYCLES) ? POR_CYCLES : HOLD_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FSM_W-1:0] POR_LAST  = FSM_W'(POR_CYCLES - 1);
  localparam logic [FSM_W-1:0] HOLD_LAST = FSM_W'(HOLD_CYCLES - 1);

  logic [NUM_IN-1:0] w_sync;
  logic              w_btn_sync;
  logic              w_raw;

  logic              r_btn_stable = 1'b0;
  logic [DB_W-1:0]   r_db_cnt     = {DB_W{1'b0}};
  state_e            r_state      = S_POR;
  logic [FSM_W-1:0]  r_cnt        = {FSM_W{1'b0}};
  state_e            w_state_nxt;
  logic [FSM_W-1:0]  w_cnt_nxt;

  sync_chain #(
    .WIDTH     (NUM_IN),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (SYNC_RESET_VAL)
  ) u_sync_in (
    .clk   (clk),
    .reset (reset),
    .d     (async_in),
    .q     (w_sync)
  );

  sync_chain #(
    .WIDTH     (1),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (BTN_REL)
  ) u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (btn_ext),
    .q     (w_btn_sync)
  );

  assign sync_out = w_sync;

`ifdef IO_COND_EDGE_EN
  logic [NUM_IN-1:0] r_prev = SYNC_RESET_VAL;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= SYNC_RESET_VAL;
    end else begin
      r_prev <= w_sync;
    end
  end

  assign rise = w_sync & ~r_prev & {NUM_IN{~reset}};
  assign fall = ~w_sync & r_prev & {NUM_IN{~reset}};
`else
  assign rise = {NUM_IN{1'b0}};
  assign fall = {NUM_IN{1'b0}};
`endif

  // Normalised to 1 = pressed; the stable level flips after DEBOUNCE_CYCLES disagreeing samples.
  assign w_raw = w_btn_sync ^ BTN_REL;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_stable <= 1'b0;
      r_db_cnt     <= {DB_W{1'b0}};
    end else if (w_raw != r_btn_stable) begin
      if (r_db_cnt == DB_LAST) begin
        r_btn_stable <= w_raw;
        r_db_cnt     <= {DB_W{1'b0}};
      end else begin
        r_db_cnt     <= r_db_cnt + 1'b1;
      end
    end else begin
      r_db_cnt <= {DB_W{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_POR;
      r_cnt   <= {FSM_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A press during HOLD restarts the hold window, even on its terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_POR: begin
        if (r_cnt == POR_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = {FSM_W{1'b0}};
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (r_btn_stable) begin
          w_cnt_nxt   = {FSM_W{1'b0}};
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = {FSM_W{1'b0}};
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (r_btn_stable) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = {FSM_W{1'b0}};
        end else begin
          w_cnt_nxt   = {FSM_W{1'b0}};
        end
      end
      default: begin
        w_state_nxt = S_POR;
        w_cnt_nxt   = {FSM_W{1'b0}};
      end
    endcase
  end

  assign btn_pressed = r_btn_stable;
  assign por_done    = r_state[ST_HOLD] | r_state[ST_RUN];
  assign sys_resetn  = r_state[ST_RUN];

endmodule

// File: tb/tb_io_reset_conditioner.sv
// Scoreboard bench for io_reset_conditioner: a history-based reference model predicts every cycle's outputs.
module tb_io_reset_conditioner;

  localparam int             NI   = 2;
  localparam int             SS   = 2;
  localparam logic [NI-1:0]  SRV  = {NI{1'b1}};
  localparam int             BAL  = 1;
  localparam int             DB   = 16;
  localparam int             PORC = 4;
  localparam int             HLD  = 8;
  localparam int             MAXC = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_ext;
  logic [NI-1:0] async_in;
  logic [NI-1:0] sync_out, rise, fall;
  logic          btn_pressed, por_done, sys_resetn;

  io_reset_conditioner #(
    .NUM_IN(NI), .SYNC_STAGES(SS), .SYNC_RESET_VAL(SRV), .BTN_ACTIVE_LOW(BAL),
    .DEBOUNCE_CYCLES(DB), .POR_CYCLES(PORC), .HOLD_CYCLES(HLD)
  ) dut (
    .clk(clk), .reset(reset), .btn_ext(btn_ext), .async_in(async_in),
    .sync_out(sync_out), .rise(rise), .fall(fall),
    .btn_pressed(btn_pressed), .por_done(por_done), .sys_resetn(sys_resetn)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NI-1:0] sync;
    logic [NI-1:0] rise;
    logic [NI-1:0] fall;
    logic          btn;
    logic          por;
    logic          rstn;
  } exp_t;

  exp_t          sb_q[$];
  bit            rst_h[MAXC];
  bit            btn_h[MAXC];
  logic [NI-1:0] in_h[MAXC];
  bit            st_h[MAXC];
  bit            por_h[MAXC];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  // Cycles before time zero count as reset cycles.
  function automatic bit rst_at(input int k);
    if (k < 0) return 1'b1;
    return rst_h[k];
  endfunction

  // Value seen at the synchroniser output: the input SS cycles ago, unless a reset intervened.
  function automatic logic [NI-1:0] sync_at(input int c);
    for (int k = c - SS; k < c; k++) if (rst_at(k)) return SRV;
    return in_h[c - SS];
  endfunction

  function automatic bit raw_at(input int c);
    for (int k = c - SS; k < c; k++) if (rst_at(k)) return 1'b0;
    return (BAL != 0) ? ~btn_h[c - SS] : btn_h[c - SS];
  endfunction

  task automatic step(input bit r, input bit b, input logic [NI-1:0] a);
    exp_t          e;
    bit            prev_st, flip, ok;
    logic [NI-1:0] s_now, s_prev;
    @(posedge clk);
    #1;
    if (cyc >= MAXC) return;
    reset = r; btn_ext = b; async_in = a;
    rst_h[cyc] = r; btn_h[cyc] = b; in_h[cyc] = a;

    // Debounced level flips only after DB consecutive non-reset cycles disagreeing with it.
    if (rst_at(cyc - 1)) begin
      st_h[cyc] = 1'b0;
    end else begin
      prev_st = st_h[cyc - 1];
      flip = 1'b1;
      for (int k = cyc - DB; k < cyc; k++)
        if (rst_at(k) || raw_at(k) == prev_st) flip = 1'b0;
      st_h[cyc] = flip ? ~prev_st : prev_st;
    end

    ok = 1'b1;
    for (int k = cyc - PORC; k < cyc; k++) if (rst_at(k)) ok = 1'b0;
    por_h[cyc] = ok;

    // Core released once HLD past cycles were all post-POR, reset-free and button-free.
    ok = 1'b1;
    for (int k = cyc - HLD; k < cyc; k++)
      if (rst_at(k) || !por_h[k] || st_h[k]) ok = 1'b0;

    s_now = sync_at(cyc);
    e.cyc  = cyc;
    e.sync = s_now;
    e.btn  = st_h[cyc];
    e.por  = por_h[cyc];
    e.rstn = ok;
    e.rise = '0;
    e.fall = '0;
`ifdef IO_COND_EDGE_EN
    if (!rst_at(cyc) && !rst_at(cyc - 1)) begin
      s_prev = sync_at(cyc - 1);
      e.rise = s_now & ~s_prev;
      e.fall = ~s_now & s_prev;
    end
`else
    s_prev = s_now;
`endif
    sb_q.push_back(e);
    cyc++;
  endtask

  task automatic run(input int n, input bit r, input bit b, input logic [NI-1:0] a);
    for (int i = 0; i < n; i++) step(r, b, a);
  endtask

  // Monitor: every cycle the DUT presents a full output set, checked against the oldest prediction.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        bad = 1'b0;
        if (sync_out !== e.sync) begin
          $display("FAIL sync_out cyc=%0d got=%b exp=%b", e.cyc, sync_out, e.sync); bad = 1'b1;
        end
        if (rise !== e.rise) begin
          $display("FAIL rise cyc=%0d got=%b exp=%b", e.cyc, rise, e.rise); bad = 1'b1;
        end
        if (fall !== e.fall) begin
          $display("FAIL fall cyc=%0d got=%b exp=%b", e.cyc, fall, e.fall); bad = 1'b1;
        end
        if (btn_pressed !== e.btn) begin
          $display("FAIL btn_pressed cyc=%0d got=%b exp=%b", e.cyc, btn_pressed, e.btn); bad = 1'b1;
        end
        if (por_done !== e.por) begin
          $display("FAIL por_done cyc=%0d got=%b exp=%b", e.cyc, por_done, e.por); bad = 1'b1;
        end
        if (sys_resetn !== e.rstn) begin
          $display("FAIL sys_resetn cyc=%0d got=%b exp=%b", e.cyc, sys_resetn, e.rstn); bad = 1'b1;
        end
        if (bad) n_err++;
      end
    end
  end

  initial begin
    logic [NI-1:0] a0;
    logic [NI-1:0] ra;
    bit            rb, rr;
    int            hold_left, rst_left;

    reset = 1'b1; btn_ext = 1'b1; async_in = SRV;
    run(3, 1'b1, 1'b1, SRV);
    run(30, 1'b0, 1'b1, SRV);
    // Short glitch that must be filtered.
    run(10, 1'b0, 1'b0, SRV);
    run(30, 1'b0, 1'b1, SRV);
    // Long press and release.
    run(40, 1'b0, 1'b0, SRV);
    run(50, 1'b0, 1'b1, SRV);
    // 5-cycle low pulse on async_in[0].
    a0 = SRV; a0[0] = 1'b0;
    run(5, 1'b0, 1'b1, a0);
    run(10, 1'b0, 1'b1, SRV);
    // Re-press timed so btn_pressed rises on the HOLD terminal count.
    run(30, 1'b0, 1'b0, SRV);
    run(7, 1'b0, 1'b1, SRV);
    run(30, 1'b0, 1'b0, SRV);
    run(50, 1'b0, 1'b1, SRV);
    // Reset pulse while the HOLD counter is at 5.
    run(30, 1'b0, 1'b0, SRV);
    run(23, 1'b0, 1'b1, SRV);
    run(1, 1'b1, 1'b1, SRV);
    run(40, 1'b0, 1'b1, SRV);

    ra = SRV; rb = 1'b1; hold_left = 20; rst_left = 0;
    for (int i = 0; i < 2800; i++) begin
      rr = 1'b0;
      if (rst_left > 0) begin
        rst_left--; rr = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_left = $urandom_range(0, 2); rr = 1'b1;
      end
      if (hold_left == 0) begin
        rb = ~rb; hold_left = $urandom_range(1, 45);
      end else begin
        hold_left--;
      end
      for (int j = 0; j < NI; j++) if ($urandom_range(0, 5) == 0) ra[j] = ~ra[j];
      step(rr, rb, ra);
    end

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_reset_conditioner.md
Name: io_reset_conditioner

Overview:
Parametrised successor to the board-level input conditioning and power-on reset logic in the FPGA top.
- Synchronises NUM_IN asynchronous inputs (e.g. RX, CTS) through a configurable-depth chain.
- Debounces the user button.
- Sequences a power-on/button reset with a guaranteed hold time.
- Drives an active-low, glitch-free sys_resetn to the core (e.g. pwhash).

Parameters:
NUM_IN, 2, number of asynchronous inputs synchronised
SYNC_STAGES, 2, flops per synchroniser chain (min 2)
SYNC_RESET_VAL, {NUM_IN{1'b1}}, reset/initial value of each chain (UART idle high)
BTN_ACTIVE_LOW, 1, 1 = button pressed when btn_ext is 0
DEBOUNCE_CYCLES, 16, consecutive cycles of disagreement before the debounced button flips (min 1)
POR_CYCLES, 4, cycles spent in POR after configuration or reset (min 1)
HOLD_CYCLES, 8, cycles sys_resetn stays low after the button is released (min 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
btn_ext  input  1  raw asynchronous user button
async_in  input  NUM_IN  raw asynchronous inputs
sync_out  output  NUM_IN  synchronised inputs
rise  output  NUM_IN  one-cycle pulse on sync_out 0->1
fall  output  NUM_IN  one-cycle pulse on sync_out 1->0
btn_pressed  output  1  debounced, polarity-normalised button (1 = pressed)
por_done  output  1  high once the POR phase has completed
sys_resetn  output  1  active-low core reset, registered

Behaviour:
- All state is updated on posedge clk. Initial-block values equal the reset values, so the block self-starts after FPGA configuration without reset.
- Reset values:
  - sync chains = SYNC_RESET_VAL
  - button chain = released level
  - debounce stable = released, counters = 0
  - state = POR
  - sys_resetn = 0, btn_pressed = 0, por_done = 0, rise = fall = 0
- Synchronisers: each async_in bit and btn_ext pass through SYNC_STAGES flops. sync_out is the last stage, so latency is SYNC_STAGES cycles.
- Edge pulses:
  - A registered previous copy of sync_out is kept.
  - rise = sync_out & ~prev, fall = ~sync_out & prev.
  - Both are forced to 0 during reset and in the first cycle after reset deasserts (prev reloaded to SYNC_RESET_VAL).
- Debounce:
  - raw = synced button, normalised by BTN_ACTIVE_LOW.
  - If raw != stable, the counter increments. When the counter == DEBOUNCE_CYCLES-1 and raw != stable, stable flips on that edge and the counter clears.
  - If raw == stable, the counter clears.
  - btn_pressed = stable. End-to-end latency is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Reset FSM is one-hot with states POR, HOLD, RUN. sys_resetn is the RUN flop itself.
  - POR: counter increments; when it reaches POR_CYCLES-1, go to HOLD and clear the counter. POR lasts exactly POR_CYCLES cycles.
  - HOLD: if btn_pressed, the counter clears. Otherwise it increments; at HOLD_CYCLES-1 go to RUN. HOLD lasts exactly HOLD_CYCLES cycles from button release.
  - RUN: if btn_pressed, go to HOLD with the counter cleared. sys_resetn drops on the edge after btn_pressed rises.
- por_done = 1 in HOLD or RUN. It returns to 0 only on reset.
- reset asserted in any state, including mid-HOLD or mid-debounce:
  - next state is POR, all counters clear, sys_resetn = 0 on the following edge.
  - reset has priority over every other event.
- Simultaneous button press and HOLD terminal count: the press wins, so the FSM stays in HOLD and the counter clears.
- Counter widths are $clog2(max(N,2)). Terminal compares use N-1, so no counter wraps.

Optional Feature:
IO_COND_EDGE_EN
- Defined: rise/fall logic and the prev register are built as described.
- Undefined: the prev register is omitted and rise/fall are tied to 0. Ports remain present so the interface is unchanged.

Decomposition:
- Package io_cond_pkg holds:
  - the state one-hot index localparams (ST_POR = 0, ST_HOLD = 1, ST_RUN = 2)
  - a ctr_width(N) function returning $clog2(max(N,2))
- Sub-module sync_chain (params WIDTH, STAGES, RESET_VAL; ports clk, reset, d, q) is instantiated twice:
  - once for async_in
  - once (WIDTH = 1) for btn_ext
- Debounce and the FSM stay inline.

Test Plan:
1. Defaults, btn_ext = 1, reset held 3 cycles then released at cycle 0 -> por_done = 1 from cycle 4; sys_resetn = 1 from cycle 12 and stays high.
2. In RUN, btn_ext = 0 for 10 cycles then 1 -> btn_pressed never asserts; sys_resetn stays 1; no state change.
3. In RUN, btn_ext = 0 held 40 cycles -> btn_pressed rises 18 cycles after the drop; sys_resetn = 0 the next cycle. After btn_ext = 1, btn_pressed falls 18 cycles later; sys_resetn = 1 exactly 8 cycles after that.
4. async_in[0] 1->0->1 with 5-cycle low (macro defined) -> sync_out[0] follows 2 cycles late; fall[0] and later rise[0] each high for exactly 1 cycle. Macro undefined -> rise = fall = 0 throughout.
5. reset pulsed for 1 cycle mid-HOLD (counter = 5) -> state POR next cycle; sys_resetn = 0; por_done = 0; the full 4 + 8 sequence repeats.
6. btn_pressed rises on the same cycle the HOLD counter = 7 -> FSM stays in HOLD; sys_resetn stays 0; the counter restarts at 0.
